muldiv_unit: RTL

//   Multi-cycle multiply/divide unit with HI/LO registers. Sits beside alu in the

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fixup cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   a_lat;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  logic               sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a_op;
  logic [WIDTH-1:0]   b_op;

  assign sgn  = ~op[0];
  assign sa   = sgn & a[WIDTH-1];
  assign sb   = sgn & b[WIDTH-1];
  assign a_op = sgn ? mag(a) : a;
  assign b_op = sgn ? mag(b) : b;

  // Multiply step: add multiplicand into the upper half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? dvs : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: upper half is remainder, lower half shifts in quotient bits.
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, dvs};
  assign div_diff = div_sh - {1'b0, dvs};
  assign div_next = div_ge
                  ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                  : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   q_neg;
  logic [WIDTH-1:0]   r_neg;
  logic               dvz;
  logic [WIDTH-1:0]   hi_fin;
  logic [WIDTH-1:0]   lo_fin;

  assign mul_res = neg_lo ? -acc : acc;
  assign q_mag   = acc[WIDTH-1:0];
  assign r_mag   = acc[2*WIDTH-1:WIDTH];
  assign q_neg   = -q_mag;
  assign r_neg   = -r_mag;
  assign dvz     = is_div && (dvs == '0);

  always_comb begin
    hi_fin = mul_res[2*WIDTH-1:WIDTH];
    lo_fin = mul_res[WIDTH-1:0];
    if (dvz) begin
      hi_fin = a_lat;
      lo_fin = {WIDTH{1'b1}};
    end else if (is_div) begin
      hi_fin = neg_hi ? r_neg : r_mag;
      lo_fin = neg_lo ? q_neg : q_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      acc         <= '0;
      dvs         <= '0;
      a_lat       <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                acc    <= {{WIDTH{1'b0}}, b_op};
                dvs    <= a_op;
                a_lat  <= a;
                is_div <= 1'b0;
                neg_lo <= sa ^ sb;
                neg_hi <= sa ^ sb;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= CALC;
              end
              3'b010, 3'b011: begin
                acc    <= {{WIDTH{1'b0}}, a_op};
                dvs    <= b_op;
                a_lat  <= a;
                is_div <= 1'b1;
                neg_lo <= sa ^ sb;
                neg_hi <= sa;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= CALC;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          hi          <= hi_fin;
          lo          <= lo_fin;
          done        <= 1'b1;
          div_by_zero <= dvz;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
